// File: rtl/decrypt_memory_if.sv
// RC4 PRGA memory/handshake bundle: S memory, encrypted ROM, decrypted RAM, start/done.
// master = decrypt engine (drives addresses/data/wrens), slave = memories and controller.
// Read data returns one WAIT state after the registered address; no backpressure.
interface decrypt_memory_if #(
  parameter int AW = 5
);
  logic          start_flag;
  logic          done_flag;
  logic          key_valid;
  logic [7:0]    s_address;
  logic [7:0]    s_data_in;
  logic [7:0]    s_data_out;
  logic          s_wren;
  logic [AW-1:0] rom_address;
  logic [7:0]    rom_data_out;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data_in;
  logic          ram_wren;

  modport master (
    input  start_flag, s_data_out, rom_data_out,
    output done_flag, key_valid, s_address, s_data_in, s_wren,
           rom_address, ram_address, ram_data_in, ram_wren
  );

  modport slave (
    output start_flag, s_data_out, rom_data_out,
    input  done_flag, key_valid, s_address, s_data_in, s_wren,
           rom_address, ram_address, ram_data_in, ram_wren
  );
endinterface

// File: rtl/decrypt_memory.sv
// RC4 keystream/decrypt stage: swaps S[i]/S[j], XORs S[S[i]+S[j]] with ROM byte, writes RAM.
// Latency: fixed 12 cycles per byte; done_flag rises 12*(n+1) edges after start is sampled.
// No backpressure: memories are single-cycle synchronous, every read gets one WAIT state.
module decrypt_memory #(
  parameter int MSG_LEN     = 32,
  parameter bit CHECK_ASCII = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  decrypt_memory_if.master bus
);
  localparam int AW = $clog2(MSG_LEN);

  typedef enum logic [3:0] {
    IDLE, SET_I, WAIT_I, GET_I, SET_J, WAIT_J, GET_J,
    WR_I, WR_J, SET_F, WAIT_F, GET_F, NEXT, DONE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_i, r_j, r_si, r_sj;
  logic [AW-1:0] r_k;
  logic [7:0]    r_s_address, r_s_data_in;
  logic          r_s_wren;
  logic [AW-1:0] r_rom_address, r_ram_address;
  logic [7:0]    r_ram_data_in;
  logic          r_ram_wren;
  logic          r_done_flag, r_key_valid;

  // Accepted plaintext alphabet: space and lowercase letters only.
  function automatic logic is_printable(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  // Per-byte sequencer; every memory-facing output is a register driven from here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_i           <= '0;
      r_j           <= '0;
      r_k           <= '0;
      r_si          <= '0;
      r_sj          <= '0;
      r_s_address   <= '0;
      r_s_data_in   <= '0;
      r_s_wren      <= 1'b0;
      r_rom_address <= '0;
      r_ram_address <= '0;
      r_ram_data_in <= '0;
      r_ram_wren    <= 1'b0;
      r_done_flag   <= 1'b0;
      r_key_valid   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_s_wren   <= 1'b0;
          r_ram_wren <= 1'b0;
          if (bus.start_flag) begin
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_key_valid <= 1'b1;
            r_state     <= SET_I;
          end
        end
        SET_I: begin
          r_i           <= r_i + 8'd1;
          r_s_address   <= r_i + 8'd1;
          r_rom_address <= r_k;
          r_state       <= WAIT_I;
        end
        WAIT_I: r_state <= GET_I;
        GET_I: begin
          r_si    <= bus.s_data_out;
          r_j     <= r_j + bus.s_data_out;
          r_state <= SET_J;
        end
        SET_J: begin
          r_s_address <= r_j;
          r_state     <= WAIT_J;
        end
        WAIT_J: r_state <= GET_J;
        GET_J: begin
          r_sj    <= bus.s_data_out;
          r_state <= WR_I;
        end
        WR_I: begin
          r_s_address <= r_i;
          r_s_data_in <= r_sj;
          r_s_wren    <= 1'b1;
          r_state     <= WR_J;
        end
        WR_J: begin
          r_s_address <= r_j;
          r_s_data_in <= r_si;
          r_s_wren    <= 1'b1;
          r_state     <= SET_F;
        end
        SET_F: begin
          // The S[j] write commits on this edge, so the lookup sees the post-swap S.
          r_s_wren    <= 1'b0;
          r_s_address <= r_si + r_sj;
          r_state     <= WAIT_F;
        end
        WAIT_F: r_state <= GET_F;
        GET_F: begin
          r_ram_address <= r_k;
          r_ram_data_in <= bus.s_data_out ^ bus.rom_data_out;
          r_ram_wren    <= 1'b1;
          r_state       <= NEXT;
        end
        NEXT: begin
          // The byte just written is still held in r_ram_data_in for the check.
          r_ram_wren <= 1'b0;
          if (CHECK_ASCII && !is_printable(r_ram_data_in)) begin
            r_key_valid <= 1'b0;
            r_done_flag <= 1'b1;
            r_state     <= DONE;
          end else if (r_k == AW'(MSG_LEN - 1)) begin
            r_done_flag <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_k     <= r_k + AW'(1);
            r_state <= SET_I;
          end
        end
        DONE: begin
          r_s_wren   <= 1'b0;
          r_ram_wren <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.s_address   = r_s_address;
  assign bus.s_data_in   = r_s_data_in;
  assign bus.s_wren      = r_s_wren;
  assign bus.rom_address = r_rom_address;
  assign bus.ram_address = r_ram_address;
  assign bus.ram_data_in = r_ram_data_in;
  assign bus.ram_wren    = r_ram_wren;
  assign bus.done_flag   = r_done_flag;
  assign bus.key_valid   = r_key_valid;
endmodule

// File: doc/decrypt_memory.md
Name: decrypt_memory

Overview:
RC4 keystream/decrypt stage (PRGA). It runs after the key-schedule swap pass has filled the 256-byte S memory. For each ciphertext byte k it reads and swaps S[i]/S[j], looks up S[S[i]+S[j]], XORs the result with the encrypted ROM byte and writes the plaintext byte to the decrypted RAM. Optionally it aborts on the first non-printable result, so a key-search controller can reject bad keys early.

Parameters:
MSG_LEN, 32, number of message bytes (ROM/RAM depth); address width is 5 bits at this default.
CHECK_ASCII, 1, 1 = abort on a decrypted byte outside {0x20, 0x61..0x7A}; 0 = never abort.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_flag  in  1  begin decryption; sampled only in IDLE
done_flag  out  1  high from entry to DONE until reset
key_valid  out  1  qualified by done_flag; 1 = every byte passed the check
s_address  out  8  S memory address
s_data_in  out  8  S memory write data
s_data_out  in  8  S memory read data (q)
s_wren  out  1  S memory write enable
rom_address  out  5  encrypted ROM address
rom_data_out  in  8  encrypted ROM read data
ram_address  out  5  decrypted RAM address
ram_data_in  out  8  decrypted RAM write data
ram_wren  out  1  decrypted RAM write enable

Behaviour:
- Reset (synchronous, active-high):
  - Next edge forces state to IDLE.
  - Clears i, j, k, si, sj and every output: addresses 0, data 0, both wrens 0, done_flag 0, key_valid 0.
  - A write already presented on the reset edge may commit; no further writes follow.
- Memory timing:
  - All addresses, data and wrens are registered outputs.
  - Read data is sampled in the state two edges after the edge that loaded the address; every read has one WAIT state.
  - A write commits on the edge ending the state that drives wren=1.
- IDLE: wrens 0. If start_flag=1, set i=0, j=0, k=0, key_valid=1 and go to SET_I. start_flag is ignored in every other state.
- Per-byte sequence (12 cycles, fixed; all arithmetic mod 256, 8-bit wrap):
  1. SET_I: i<=i+1; s_address<=i+1; rom_address<=k.
  2. WAIT_I.
  3. GET_I: si<=s_data_out; j<=j+s_data_out.
  4. SET_J: s_address<=j.
  5. WAIT_J.
  6. GET_J: sj<=s_data_out.
  7. WR_I: s_address<=i; s_data_in<=sj; s_wren<=1.
  8. WR_J: s_address<=j; s_data_in<=si; s_wren<=1.
  9. SET_F: s_wren<=0; s_address<=si+sj.
  10. WAIT_F.
  11. GET_F: ram_address<=k; ram_data_in<=s_data_out^rom_data_out; ram_wren<=1.
  12. NEXT: ram_wren<=0. If CHECK_ASCII and the written byte is invalid: key_valid<=0, done_flag<=1, go to DONE. Else if k==MSG_LEN-1: done_flag<=1, go to DONE. Else k<=k+1, go to SET_I.
- i==j: both writes target the same address with the same value; S is unchanged. No special casing.
- The lookup read of S[si+sj] is issued after both swap writes have committed, so it sees the post-swap S.
- An aborted byte is still written to RAM. Bytes after the abort are not written.
- DONE: all wrens 0. Holds done_flag and key_valid until reset. start_flag is ignored.
- Latency: if E0 is the IDLE edge sampling start_flag=1, DONE (done_flag=1) begins at edge E0+12*(n+1), where n = index of the last processed byte.

Test Plan:
- S identity (S[x]=x), ROM all 0x00, CHECK_ASCII=1, start pulse -> ram[0]=0x02; done_flag=1 at E0+12; key_valid=0; S[1]=1 (i==j swap); ram[1..31] untouched.
- S identity, ROM[0]=0x63 -> ram[0]=0x61 ('a'); byte 1 proceeds (i=2, j=3; after swap S[2]=3, S[3]=2).
- Preloaded KSA output S for key 24'h000249, ROM = golden-model keystream XOR 32 spaces -> ram all 0x20; key_valid=1; done_flag at E0+384; final S matches the model, including j wrap past 0xFF.
- Same stimulus but byte 31 decrypts to 0x7B -> all 32 bytes written; key_valid=0; done_flag at E0+384. With CHECK_ASCII=0 -> key_valid=1.
- reset asserted during WR_I of byte 5 -> next cycle all outputs 0 and state IDLE; a following start restarts at k=0, i=0, j=0.
- start_flag held high through DONE, or pulsed mid-run -> no restart and no extra writes; done_flag stays 1 until reset.
